// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared types and constants for the pixel packer
//
// Purpose : pixel struct, byte/stream widths and packing phase encoding.
// Ports   : none (package).

package pixel_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   localparam int BYTES_PER_PIXEL = 3;
   localparam int STREAM_W        = 32;

   // Bytes carried between pixels; after P0 a whole pixel is still waiting.
   localparam int RESIDUE_W = BYTES_PER_PIXEL * 8;

   typedef enum logic [1:0] {
      P0 = 2'd0,
      P1 = 2'd1,
      P2 = 2'd2,
      P3 = 2'd3
   } phase_t;

endpackage

// File: rtl/stream_reg.sv
// rtl/stream_reg.sv - one-entry stream output register with pass-through backpressure
//
// Purpose : holds one payload word; accepts a new word in the same cycle the
//           held word leaves.
// Ports   : clk, reset (async active-low)
//           s_tdata/s_tvalid/s_tready - upstream side
//           m_tdata/m_tvalid/m_tready - downstream side

module stream_reg #(
   parameter int W = 34
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] s_tdata,
   input  logic         s_tvalid,
   output logic         s_tready,
   output logic [W-1:0] m_tdata,
   output logic         m_tvalid,
   input  logic         m_tready
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   assign s_tready = !valid_q || m_tready;
   assign m_tvalid = valid_q;
   assign m_tdata  = data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (s_tvalid && s_tready) begin
         valid_d = 1'b1;
         data_d  = s_tdata;
      end else if (m_tready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/pixel_packer.sv
// rtl/pixel_packer.sv - packs 24-bit RGB pixels, 4 pixels into 3 32-bit stream words
//
// Purpose : serialises pixels to bytes R,G,B and packs them little-endian into
//           32-bit words with start-of-frame (out_user) and end-of-line
//           (out_last) markers; flags end of frame and malformed lines.
// Ports   : clk, reset (async active-low)
//           r/g/b/valid/first/last_x/last_y, ready   - pixel input
//           out_data/out_valid/out_user/out_last, out_ready - word output
//           frame_done - one-cycle pulse on the frame's final word transfer
//           line_err   - sticky line-format error
// Macro   : PIXEL_PACKER_LINE_CHECK_EN enables the per-line pixel counter
//           behind line_err; otherwise line_err is tied low.

module pixel_packer
   import pixel_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          r,
   input  logic [7:0]          g,
   input  logic [7:0]          b,
   input  logic                valid,
   input  logic                first,
   input  logic                last_x,
   input  logic                last_y,
   output logic                ready,
   output logic [STREAM_W-1:0] out_data,
   output logic                out_valid,
   output logic                out_user,
   output logic                out_last,
   input  logic                out_ready,
   output logic                frame_done,
   output logic                line_err
);

   if ((IMG_W % 4) != 0 || IMG_W < 4) begin : g_bad_img_w
      $error("IMG_W must be a positive multiple of 4");
   end
   if (IMG_H < 1) begin : g_bad_img_h
      $error("IMG_H must be positive");
   end

   pixel_t                pix;
   phase_t                phase_q, phase_d, eff_phase;
   logic [RESIDUE_W-1:0]  residue_q, residue_d;
   logic                  grp_first_q, grp_first_d;
   logic                  eof_q, eof_d;
   logic                  accept;
   logic                  word_valid, word_user, word_last;
   logic [STREAM_W-1:0]   word_data;
   logic [STREAM_W+1:0]   held;

   assign pix    = '{r: r, g: g, b: b};
   assign accept = valid && ready;

   always_comb begin
      // A frame start restarts packing regardless of any half-built group.
      eff_phase   = first ? P0 : phase_q;
      phase_d     = phase_q;
      residue_d   = residue_q;
      grp_first_d = grp_first_q;
      word_valid  = 1'b0;
      word_data   = '0;
      word_user   = 1'b0;
      word_last   = 1'b0;
      if (accept) begin
         case (eff_phase)
            P0: begin
               residue_d   = {pix.b, pix.g, pix.r};
               grp_first_d = first;
               phase_d     = P1;
            end
            P1: begin
               word_valid = 1'b1;
               word_data  = {pix.r, residue_q};
               word_user  = grp_first_q;
               residue_d  = {8'h00, pix.b, pix.g};
               phase_d    = P2;
            end
            P2: begin
               word_valid = 1'b1;
               word_data  = {pix.g, pix.r, residue_q[15:0]};
               residue_d  = {16'h0000, pix.b};
               phase_d    = P3;
            end
            default: begin
               word_valid = 1'b1;
               word_data  = {pix.b, pix.g, pix.r, residue_q[7:0]};
               word_last  = last_x;
               residue_d  = '0;
               phase_d    = P0;
            end
         endcase
         // Line end drops whatever part of a group is still buffered.
         if (last_x) begin
            phase_d   = P0;
            residue_d = '0;
         end
      end
      // Remembers whether the word now entering the register closes the frame.
      eof_d = word_valid ? (word_last && last_y) : eof_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_q     <= P0;
         residue_q   <= '0;
         grp_first_q <= 1'b0;
         eof_q       <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         residue_q   <= residue_d;
         grp_first_q <= grp_first_d;
         eof_q       <= eof_d;
      end
   end

   stream_reg #(.W(STREAM_W + 2)) u_out_reg (
      .clk      (clk),
      .reset    (reset),
      .s_tdata  ({word_data, word_user, word_last}),
      .s_tvalid (word_valid),
      .s_tready (ready),
      .m_tdata  (held),
      .m_tvalid (out_valid),
      .m_tready (out_ready)
   );

   assign out_data = held[STREAM_W+1:2];
   assign out_user = held[1];
   assign out_last = held[0];

   assign frame_done = out_valid && out_ready && out_last && eof_q;

`ifdef PIXEL_PACKER_LINE_CHECK_EN
   localparam int CNT_W = $clog2(IMG_W + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             err_q, err_d;

   always_comb begin
      cnt_inc = (first ? '0 : cnt_q) + 1'b1;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (accept) begin
         cnt_d = cnt_inc;
         if (last_x) begin
            cnt_d = '0;
            if (cnt_inc != CNT_W'(IMG_W) || eff_phase != P3) begin
               err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign line_err = err_q;
`else
   assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_packer.sv
// tb/tb_pixel_packer.sv - self-checking bench for pixel_packer

`timescale 1ns/1ps

module tb_pixel_packer;

   localparam int IMG_W = 640;
   localparam int IMG_H = 4;
`ifdef PIXEL_PACKER_LINE_CHECK_EN
   localparam bit LC_EN = 1'b1;
`else
   localparam bit LC_EN = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       first;
      logic       lx;
      logic       ly;
   } pix_t;

   typedef struct packed {
      logic [31:0] d;
      logic        u;
      logic        l;
      logic        eof;
   } word_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  r = '0, g = '0, b = '0;
   logic        valid = 1'b0, first = 1'b0, last_x = 1'b0, last_y = 1'b0;
   logic        ready;
   logic [31:0] out_data;
   logic        out_valid, out_user, out_last;
   logic        out_ready = 1'b1;
   logic        frame_done, line_err;

   pixel_packer #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk        (clk),
      .reset      (reset),
      .r          (r),
      .g          (g),
      .b          (b),
      .valid      (valid),
      .first      (first),
      .last_x     (last_x),
      .last_y     (last_y),
      .ready      (ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_user   (out_user),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .frame_done (frame_done),
      .line_err   (line_err)
   );

   always #5 clk = ~clk;

   int    n_chk = 0, n_pass = 0, n_fail = 0;
   pix_t  grp[$];
   word_t exp_q[$];
   word_t got_q[$];
   int    m_cnt = 0;
   bit    m_err = 1'b0;
   int    fd_cnt = 0, fd_at = -1;
   bit    prev_stall = 1'b0;
   logic [33:0] prev_out = '0;
   bit    rnd_oready = 1'b0, rnd_gap = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: bytes R,G,B per pixel, word k of a group complete once its
   // fourth byte has arrived, i.e. when the group holds k+2 pixels.
   task automatic model_accept(input pix_t p);
      logic [7:0] by[$];
      word_t w;
      int k;
      if (p.first) begin
         grp.delete();
         m_cnt = 0;
      end
      grp.push_back(p);
      m_cnt++;
      k = grp.size() - 2;
      if (k >= 0) begin
         foreach (grp[i]) begin
            by.push_back(grp[i].r);
            by.push_back(grp[i].g);
            by.push_back(grp[i].b);
         end
         w.d   = {by[4*k+3], by[4*k+2], by[4*k+1], by[4*k]};
         w.u   = (k == 0) && grp[0].first;
         w.l   = (k == 2) && p.lx;
         w.eof = w.l && p.ly;
         exp_q.push_back(w);
      end
      if (LC_EN && p.lx && (m_cnt != IMG_W || grp.size() != 4)) m_err = 1'b1;
      if (grp.size() == 4 || p.lx) grp.delete();
      if (p.lx) m_cnt = 0;
   endtask

   always @(negedge clk) begin
      word_t e;
      bit    have, tx;
      if (!reset) begin
         exp_q.delete();
         grp.delete();
         m_cnt = 0;
         m_err = 1'b0;
         prev_stall = 1'b0;
      end else begin
         have = exp_q.size() != 0;
         e    = have ? exp_q[0] : '0;
         tx   = out_valid && out_ready;
         chk("out_valid", out_valid, have);
         chk("ready", ready, !have || out_ready);
         chk("line_err", line_err, m_err);
         if (have && out_valid) begin
            chk("out_data", out_data, e.d);
            chk("out_user", out_user, e.u);
            chk("out_last", out_last, e.l);
         end
         chk("frame_done", frame_done, tx && have && e.eof);
         if (prev_stall && out_valid) chk("hold", {out_data[29:0], out_user, out_last}, prev_out[31:0]);
         if (frame_done) begin
            fd_cnt++;
            fd_at = got_q.size();
         end
         if (tx && have) begin
            got_q.push_back('{d: out_data, u: out_user, l: out_last, eof: 1'b0});
            void'(exp_q.pop_front());
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {out_data, out_user, out_last};
         if (valid && ready)
            model_accept('{r: r, g: g, b: b, first: first, lx: last_x, ly: last_y});
      end
   end

   function automatic pix_t mkpix(input bit f, input bit lx, input bit ly);
      pix_t p;
      p.r = 8'($urandom);
      p.g = 8'($urandom);
      p.b = 8'($urandom);
      p.first = f;
      p.lx = lx;
      p.ly = ly;
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_oready) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_pix(input pix_t p);
      bit acc;
      acc = 1'b0;
      {r, g, b} = {p.r, p.g, p.b};
      {first, last_x, last_y} = {p.first, p.lx, p.ly};
      valid = 1'b1;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         acc = ready;
         tick();
      end
      valid = 1'b0;
      if (!acc) chk("accept_timeout", acc, 1'b1);
      if (rnd_gap && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
   endtask

   task automatic send_line(input int n, input bit f0, input bit ly);
      for (int i = 0; i < n; i++) send_pix(mkpix(f0 && i == 0, i == n - 1, ly));
   endtask

   task automatic drain();
      rnd_oready = 1'b0;
      out_ready  = 1'b1;
      for (int i = 0; i < 10 && out_valid; i++) tick();
      chk("drain", out_valid, 1'b0);
   endtask

   task automatic check_line_words(input string tag, input int nwords);
      int nl, li;
      nl = 0;
      li = -1;
      foreach (got_q[i]) if (got_q[i].l) begin
         nl++;
         li = i;
      end
      chk({tag, "_words"}, got_q.size(), nwords);
      chk({tag, "_last_cnt"}, nl, 1);
      chk({tag, "_last_pos"}, li, nwords - 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      pix_t px[4];
      int   nst;

      // Reset state
      idle(2);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_flags", {out_user, out_last, frame_done, line_err}, 4'b0000);
      chk("rst_ready", ready, 1'b1);
      reset = 1'b1;
      idle(1);

      // Directed group
      got_q.delete();
      send_pix('{r: 8'h01, g: 8'h02, b: 8'h03, first: 1'b1, lx: 1'b0, ly: 1'b0});
      send_pix('{r: 8'h04, g: 8'h05, b: 8'h06, first: 1'b0, lx: 1'b0, ly: 1'b0});
      send_pix('{r: 8'h07, g: 8'h08, b: 8'h09, first: 1'b0, lx: 1'b0, ly: 1'b0});
      send_pix('{r: 8'h0A, g: 8'h0B, b: 8'h0C, first: 1'b0, lx: 1'b0, ly: 1'b0});
      drain();
      chk("dir_count", got_q.size(), 3);
      chk("dir_w0", got_q[0].d, 32'h04030201);
      chk("dir_w0_user", got_q[0].u, 1'b1);
      chk("dir_w1", got_q[1].d, 32'h08070605);
      chk("dir_w1_user", got_q[1].u, 1'b0);
      chk("dir_w2", got_q[2].d, 32'h0C0B0A09);

      // Full line, no backpressure
      got_q.delete();
      send_line(IMG_W, 1'b1, 1'b0);
      drain();
      check_line_words("line", 480);

      // Line with a 10-cycle downstream stall
      got_q.delete();
      for (int i = 0; i < 8; i++) send_pix(mkpix(i == 0, 1'b0, 1'b0));
      idle(1);
      out_ready = 1'b0;
      nst = 0;
      while (ready && nst < 4) begin
         send_pix(mkpix(1'b0, 1'b0, 1'b0));
         nst++;
      end
      chk("stall_depth", nst, 2);
      chk("stall_ready", ready, 1'b0);
      idle(10);
      chk("stall_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      for (int i = 8 + nst; i < IMG_W; i++) send_pix(mkpix(1'b0, i == IMG_W - 1, 1'b0));
      drain();
      check_line_words("stall", 480);

      // Short line: last_x on pixel 6, then a fresh group without first
      got_q.delete();
      rnd_oready = 1'b1;
      send_line(6, 1'b1, 1'b0);
      drain();
      chk("short_words", got_q.size(), 4);
      chk("short_no_last", got_q[3].l, 1'b0);
      chk("short_err", line_err, LC_EN);
      send_line(4, 1'b0, 1'b0);
      drain();
      chk("realign_words", got_q.size(), 7);
      chk("realign_last", got_q[6].l, 1'b1);

      // Reset while a word is pending
      out_ready = 1'b0;
      send_pix(mkpix(1'b1, 1'b0, 1'b0));
      send_pix(mkpix(1'b0, 1'b0, 1'b0));
      chk("pre_reset_valid", out_valid, 1'b1);
      reset = 1'b0;
      #1;
      chk("mid_reset_valid", out_valid, 1'b0);
      chk("mid_reset_data", out_data, 32'h0);
      chk("mid_reset_ready", ready, 1'b1);
      chk("mid_reset_err", line_err, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      out_ready = 1'b1;
      got_q.delete();
      for (int i = 0; i < 4; i++) begin
         px[i] = mkpix(1'b0, 1'b0, 1'b0);
         send_pix(px[i]);
      end
      drain();
      chk("post_reset_words", got_q.size(), 3);
      chk("post_reset_w0", got_q[0].d, {px[1].r, px[0].b, px[0].g, px[0].r});

      // Frame of IMG_H lines with random gaps and backpressure
      got_q.delete();
      fd_cnt = 0;
      fd_at = -1;
      rnd_gap = 1'b1;
      rnd_oready = 1'b1;
      for (int ln = 0; ln < IMG_H; ln++) send_line(IMG_W, ln == 0, ln == IMG_H - 1);
      drain();
      chk("frame_words", got_q.size(), IMG_H * 480);
      chk("frame_done_cnt", fd_cnt, 1);
      chk("frame_done_pos", fd_at, IMG_H * 480 - 1);
      chk("frame_err", line_err, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
